stage_if: RTL and testbench

STAGE_IF -- requirements
Module: stage_if

---
 rtl/stage_if_if.sv | 23 ++
 rtl/stage_if.sv | 59 +++++
 tb/tb_stage_if.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/stage_if_if.sv
// stage_if_if: fetch-stage bundle between the IF stage (master) and its environment (slave).
interface stage_if_if;
  logic        ihit;
  logic [31:0] iload;
  logic        stall;
  logic        flush;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        halt_in;
  logic        iREN;
  logic [31:0] iaddr;
  logic [31:0] imemload_out;
  logic [31:0] npc_out;
  logic        valid_out;
  modport master (
    input  ihit, iload, stall, flush, redirect, redirect_pc, halt_in,
    output iREN, iaddr, imemload_out, npc_out, valid_out
  );
  modport slave (
    output ihit, iload, stall, flush, redirect, redirect_pc, halt_in,
    input  iREN, iaddr, imemload_out, npc_out, valid_out
  );
endinterface

// File: rtl/stage_if.sv
// stage_if: instruction fetch stage with PC, IF/ID latch and a FETCH/HALTED state machine.
module stage_if #(
  parameter logic [31:0] PC_INIT = 32'h0000_0000
) (
  input logic        CLK,
  input logic        RST,
  stage_if_if.master bus
);
  typedef enum logic {FETCH, HALTED} state_t;
  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d, imem_q, imem_d, npc_q, npc_d, pc_inc;
  logic        valid_q, valid_d;
  assign pc_inc = pc_q + 32'd4;
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    imem_d  = imem_q;
    npc_d   = npc_q;
    valid_d = valid_q;
    if (state_q == FETCH) begin
      if (bus.halt_in) begin
        state_d = HALTED;
        {imem_d, npc_d, valid_d} = '0;
      end else if (bus.redirect) begin
        pc_d = {bus.redirect_pc[31:2], 2'b00};
        {imem_d, npc_d, valid_d} = '0;
      end else begin
        if (!bus.stall) begin
          pc_d    = bus.ihit ? pc_inc : pc_q;
          imem_d  = bus.ihit ? bus.iload : '0;
          npc_d   = bus.ihit ? pc_inc : '0;
          valid_d = bus.ihit;
        end
        // flush squashes the latch even when stalled; PC still follows stall/ihit
        if (bus.flush) {imem_d, npc_d, valid_d} = '0;
      end
    end
  end
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= FETCH;
      pc_q    <= PC_INIT;
      imem_q  <= '0;
      npc_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      imem_q  <= imem_d;
      npc_q   <= npc_d;
      valid_q <= valid_d;
    end
  end
  assign bus.iREN         = (state_q == FETCH);
  assign bus.iaddr        = pc_q;
  assign bus.imemload_out = imem_q;
  assign bus.npc_out      = npc_q;
  assign bus.valid_out    = valid_q;
endmodule

// File: tb/tb_stage_if.sv
// tb_stage_if: scenario tasks with a scoreboard queue of expected fetch-stage outputs.
module tb_stage_if;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int compared = 0;
  int mismatched = 0;
  always #5 clk = ~clk;
  stage_if_if bus ();
  stage_if #(.PC_INIT(32'h0000_0000)) dut (.CLK(clk), .RST(rst), .bus(bus));
  typedef struct packed {
    logic        ihit;
    logic [31:0] iload;
    logic        stall;
    logic        flush;
    logic        redir;
    logic [31:0] rpc;
    logic        halt;
  } st_t;
  typedef struct packed {
    logic [31:0] ia;
    logic        ren;
    logic [31:0] im;
    logic [31:0] np;
    logic        v;
  } exp_t;
  exp_t exp_q[$];
  function automatic st_t mk(logic ih, logic [31:0] ld, logic stl, logic fl, logic rd, logic [31:0] rp, logic hl);
    return '{ihit: ih, iload: ld, stall: stl, flush: fl, redir: rd, rpc: rp, halt: hl};
  endfunction
  function automatic exp_t ex(logic [31:0] ia, logic ren, logic [31:0] im, logic [31:0] np, logic v);
    return '{ia: ia, ren: ren, im: im, np: np, v: v};
  endfunction
  function automatic exp_t act();
    return '{ia: bus.iaddr, ren: bus.iREN, im: bus.imemload_out, np: bus.npc_out, v: bus.valid_out};
  endfunction
  task automatic idle();
    bus.ihit = 0; bus.iload = '0; bus.stall = 0; bus.flush = 0;
    bus.redirect = 0; bus.redirect_pc = '0; bus.halt_in = 0;
  endtask
  task automatic step(st_t s);
    bus.ihit = s.ihit; bus.iload = s.iload; bus.stall = s.stall; bus.flush = s.flush;
    bus.redirect = s.redir; bus.redirect_pc = s.rpc; bus.halt_in = s.halt;
    @(posedge clk);
    #1;
  endtask
  task automatic pulse_reset();
    idle();
    rst = 1;
    #2;
    rst = 0;
  endtask
  task automatic test_reset();
    exp_t e, a;
    idle();
    rst = 1;
    exp_q.push_back(ex(32'h0, 1, 32'h0, 32'h0, 0));
    #1;
    e = exp_q.pop_front();
    a = act();
    compared++;
    if (a !== e) begin
      mismatched++;
      $display("FAIL reset: got ia=%h ren=%b im=%h npc=%h v=%b want ia=%h ren=%b im=%h npc=%h v=%b",
               a.ia, a.ren, a.im, a.np, a.v, e.ia, e.ren, e.im, e.np, e.v);
    end
    @(posedge clk);
    #1;
    rst = 0;
  endtask
  task automatic test_sequential();
    st_t s[$]; exp_t x[$]; exp_t e, a;
    pulse_reset();
    s.push_back(mk(1, 32'h2001_0005, 0, 0, 0, 0, 0)); x.push_back(ex(32'h4, 1, 32'h2001_0005, 32'h4, 1));
    s.push_back(mk(1, 32'h2002_0007, 0, 0, 0, 0, 0)); x.push_back(ex(32'h8, 1, 32'h2002_0007, 32'h8, 1));
    s.push_back(mk(1, 32'h0000_0000, 0, 0, 0, 0, 0)); x.push_back(ex(32'hC, 1, 32'h0, 32'hC, 1));
    foreach (s[i]) begin
      exp_q.push_back(x[i]);
      step(s[i]);
      e = exp_q.pop_front(); a = act(); compared++;
      if (a !== e) begin
        mismatched++;
        $display("FAIL sequential step %0d: got ia=%h ren=%b im=%h npc=%h v=%b want ia=%h ren=%b im=%h npc=%h v=%b",
                 i, a.ia, a.ren, a.im, a.np, a.v, e.ia, e.ren, e.im, e.np, e.v);
      end
    end
  endtask
  task automatic test_redirect();
    st_t s[$]; exp_t x[$]; exp_t e, a;
    pulse_reset();
    s.push_back(mk(0, 0, 0, 0, 1, 32'h10, 0));            x.push_back(ex(32'h10, 1, 0, 0, 0));
    s.push_back(mk(1, 32'hDEAD_BEEF, 0, 0, 1, 32'h43, 0)); x.push_back(ex(32'h40, 1, 0, 0, 0));
    s.push_back(mk(1, 32'h1111_2222, 1, 0, 1, 32'h80, 0)); x.push_back(ex(32'h80, 1, 0, 0, 0));
    s.push_back(mk(0, 0, 0, 0, 1, 32'h40, 0));            x.push_back(ex(32'h40, 1, 0, 0, 0));
    s.push_back(mk(1, 32'h3333_4444, 0, 0, 0, 0, 0));     x.push_back(ex(32'h44, 1, 32'h3333_4444, 32'h44, 1));
    foreach (s[i]) begin
      exp_q.push_back(x[i]);
      step(s[i]);
      e = exp_q.pop_front(); a = act(); compared++;
      if (a !== e) begin
        mismatched++;
        $display("FAIL redirect step %0d: got ia=%h ren=%b im=%h npc=%h v=%b want ia=%h ren=%b im=%h npc=%h v=%b",
                 i, a.ia, a.ren, a.im, a.np, a.v, e.ia, e.ren, e.im, e.np, e.v);
      end
    end
  endtask
  task automatic test_stall();
    st_t s[$]; exp_t x[$]; exp_t e, a;
    pulse_reset();
    s.push_back(mk(0, 0, 0, 0, 1, 32'h1C, 0));            x.push_back(ex(32'h1C, 1, 0, 0, 0));
    s.push_back(mk(1, 32'hAAAA_0001, 0, 0, 0, 0, 0));     x.push_back(ex(32'h20, 1, 32'hAAAA_0001, 32'h20, 1));
    s.push_back(mk(1, 32'hBBBB_0002, 1, 0, 0, 0, 0));     x.push_back(ex(32'h20, 1, 32'hAAAA_0001, 32'h20, 1));
    s.push_back(mk(1, 32'hBBBB_0003, 1, 0, 0, 0, 0));     x.push_back(ex(32'h20, 1, 32'hAAAA_0001, 32'h20, 1));
    s.push_back(mk(1, 32'hCCCC_0004, 0, 0, 0, 0, 0));     x.push_back(ex(32'h24, 1, 32'hCCCC_0004, 32'h24, 1));
    s.push_back(mk(1, 32'hDDDD_0005, 1, 1, 0, 0, 0));     x.push_back(ex(32'h24, 1, 0, 0, 0));
    foreach (s[i]) begin
      exp_q.push_back(x[i]);
      step(s[i]);
      e = exp_q.pop_front(); a = act(); compared++;
      if (a !== e) begin
        mismatched++;
        $display("FAIL stall step %0d: got ia=%h ren=%b im=%h npc=%h v=%b want ia=%h ren=%b im=%h npc=%h v=%b",
                 i, a.ia, a.ren, a.im, a.np, a.v, e.ia, e.ren, e.im, e.np, e.v);
      end
    end
  endtask
  task automatic test_miss_flush();
    st_t s[$]; exp_t x[$]; exp_t e, a;
    pulse_reset();
    s.push_back(mk(0, 0, 0, 0, 1, 32'h2C, 0));            x.push_back(ex(32'h2C, 1, 0, 0, 0));
    s.push_back(mk(1, 32'h1234_5678, 0, 0, 0, 0, 0));     x.push_back(ex(32'h30, 1, 32'h1234_5678, 32'h30, 1));
    s.push_back(mk(0, 32'hFFFF_0000, 0, 0, 0, 0, 0));     x.push_back(ex(32'h30, 1, 0, 0, 0));
    s.push_back(mk(0, 32'hFFFF_0001, 0, 0, 0, 0, 0));     x.push_back(ex(32'h30, 1, 0, 0, 0));
    s.push_back(mk(1, 32'h8765_4321, 0, 1, 0, 0, 0));     x.push_back(ex(32'h34, 1, 0, 0, 0));
    s.push_back(mk(1, 32'h0BAD_F00D, 0, 0, 0, 0, 0));     x.push_back(ex(32'h38, 1, 32'h0BAD_F00D, 32'h38, 1));
    foreach (s[i]) begin
      exp_q.push_back(x[i]);
      step(s[i]);
      e = exp_q.pop_front(); a = act(); compared++;
      if (a !== e) begin
        mismatched++;
        $display("FAIL miss_flush step %0d: got ia=%h ren=%b im=%h npc=%h v=%b want ia=%h ren=%b im=%h npc=%h v=%b",
                 i, a.ia, a.ren, a.im, a.np, a.v, e.ia, e.ren, e.im, e.np, e.v);
      end
    end
  endtask
  task automatic test_halt();
    st_t s[$]; exp_t x[$]; exp_t e, a;
    pulse_reset();
    s.push_back(mk(0, 0, 0, 0, 1, 32'h4C, 0));            x.push_back(ex(32'h4C, 1, 0, 0, 0));
    s.push_back(mk(1, 32'h5555_AAAA, 0, 0, 0, 0, 0));     x.push_back(ex(32'h50, 1, 32'h5555_AAAA, 32'h50, 1));
    s.push_back(mk(1, 32'h6666_BBBB, 0, 0, 1, 32'h200, 1)); x.push_back(ex(32'h50, 0, 0, 0, 0));
    s.push_back(mk(1, 32'h7777_CCCC, 0, 0, 1, 32'h100, 0)); x.push_back(ex(32'h50, 0, 0, 0, 0));
    s.push_back(mk(1, 32'h8888_DDDD, 0, 0, 0, 0, 0));     x.push_back(ex(32'h50, 0, 0, 0, 0));
    foreach (s[i]) begin
      exp_q.push_back(x[i]);
      step(s[i]);
      e = exp_q.pop_front(); a = act(); compared++;
      if (a !== e) begin
        mismatched++;
        $display("FAIL halt step %0d: got ia=%h ren=%b im=%h npc=%h v=%b want ia=%h ren=%b im=%h npc=%h v=%b",
                 i, a.ia, a.ren, a.im, a.np, a.v, e.ia, e.ren, e.im, e.np, e.v);
      end
    end
    bus.ihit = 1; bus.iload = 32'h9999_EEEE;
    rst = 1;
    exp_q.push_back(ex(32'h0, 1, 0, 0, 0));
    #1;
    e = exp_q.pop_front(); a = act(); compared++;
    if (a !== e) begin
      mismatched++;
      $display("FAIL halt_reset: got ia=%h ren=%b im=%h npc=%h v=%b want ia=%h ren=%b im=%h npc=%h v=%b",
               a.ia, a.ren, a.im, a.np, a.v, e.ia, e.ren, e.im, e.np, e.v);
    end
    #1;
    rst = 0;
    exp_q.push_back(ex(32'h4, 1, 32'hAB00_0001, 32'h4, 1));
    step(mk(1, 32'hAB00_0001, 0, 0, 0, 0, 0));
    e = exp_q.pop_front(); a = act(); compared++;
    if (a !== e) begin
      mismatched++;
      $display("FAIL halt_refetch: got ia=%h ren=%b im=%h npc=%h v=%b want ia=%h ren=%b im=%h npc=%h v=%b",
               a.ia, a.ren, a.im, a.np, a.v, e.ia, e.ren, e.im, e.np, e.v);
    end
  endtask
  task automatic test_stall_reset();
    exp_t e, a;
    pulse_reset();
    step(mk(0, 0, 0, 0, 1, 32'h600, 0));
    step(mk(1, 32'h4242_4242, 0, 0, 0, 0, 0));
    bus.stall = 1;
    rst = 1;
    exp_q.push_back(ex(32'h0, 1, 0, 0, 0));
    #1;
    e = exp_q.pop_front(); a = act(); compared++;
    if (a !== e) begin
      mismatched++;
      $display("FAIL stall_reset: got ia=%h ren=%b im=%h npc=%h v=%b want ia=%h ren=%b im=%h npc=%h v=%b",
               a.ia, a.ren, a.im, a.np, a.v, e.ia, e.ren, e.im, e.np, e.v);
    end
    #1;
    rst = 0;
  endtask
  task automatic test_wrap();
    st_t s[$]; exp_t x[$]; exp_t e, a;
    pulse_reset();
    s.push_back(mk(0, 0, 0, 0, 1, 32'hFFFF_FFFF, 0));     x.push_back(ex(32'hFFFF_FFFC, 1, 0, 0, 0));
    s.push_back(mk(1, 32'hCAFE_0001, 0, 0, 0, 0, 0));     x.push_back(ex(32'h0, 1, 32'hCAFE_0001, 32'h0, 1));
    s.push_back(mk(1, 32'hCAFE_0002, 0, 0, 0, 0, 0));     x.push_back(ex(32'h4, 1, 32'hCAFE_0002, 32'h4, 1));
    foreach (s[i]) begin
      exp_q.push_back(x[i]);
      step(s[i]);
      e = exp_q.pop_front(); a = act(); compared++;
      if (a !== e) begin
        mismatched++;
        $display("FAIL wrap step %0d: got ia=%h ren=%b im=%h npc=%h v=%b want ia=%h ren=%b im=%h npc=%h v=%b",
                 i, a.ia, a.ren, a.im, a.np, a.v, e.ia, e.ren, e.im, e.np, e.v);
      end
    end
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end
  initial begin
    test_reset();
    test_sequential();
    test_redirect();
    test_stall();
    test_miss_flush();
    test_halt();
    test_stall_reset();
    test_wrap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
